// File: rtl/ifetch.sv
// Instruction fetch stage: PC, single-outstanding ROM read sequencing, 2-entry
// instruction FIFO toward decode, redirect handling and sticky fetch error.
module ifetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_LENGTH = 14,
    parameter int          ROM_DELAY   = 5,
    parameter int          TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_data,
    input  logic        mem_oe,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HALT
    } state_t;

    localparam int          SETTLE   = ROM_DELAY + 2;
    localparam int          CNT_MAX  = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int          CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [32:0] PC_LIMIT = 33'd1 << (ADDR_LENGTH + 2);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pc;
    logic               r_discard;
    logic               r_err;
    logic               r_mem_re;
    logic [31:0]        r_mem_addr;

    // FIFO as a two-slot shift register so the head drives the outputs directly.
    logic               r_v0;
    logic               r_v1;
    logic [31:0]        r_d0;
    logic [31:0]        r_d1;
    logic [31:0]        r_p0;
    logic [31:0]        r_p1;

    state_t             w_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [31:0]        w_pc;
    logic               w_discard;
    logic               w_err;
    logic               w_mem_re;
    logic [31:0]        w_mem_addr;
    logic               w_try;
    logic               w_push;
    logic               w_pop;
    logic               w_v0;
    logic               w_v1;
    logic [31:0]        w_d0;
    logic [31:0]        w_d1;
    logic [31:0]        w_p0;
    logic [31:0]        w_p1;
    logic [1:0]         w_occ;

    assign w_pop  = r_v0 & inst_ready;
    assign w_push = (r_state == S_WAIT) && mem_oe && !r_discard && !redirect_valid;

    always_comb begin
        // NOTE: every variable gets its default first so no latch is inferred.
        w_v0 = r_v0;
        w_v1 = r_v1;
        w_d0 = r_d0;
        w_d1 = r_d1;
        w_p0 = r_p0;
        w_p1 = r_p1;
        if (w_pop) begin
            w_v0 = r_v1;
            w_d0 = r_d1;
            w_p0 = r_p1;
            w_v1 = 1'b0;
        end
        if (w_push) begin
            if (!w_v0) begin
                w_v0 = 1'b1;
                w_d0 = mem_data;
                w_p0 = r_pc;
            end else begin
                w_v1 = 1'b1;
                w_d1 = mem_data;
                w_p1 = r_pc;
            end
        end
        if (redirect_valid) begin
            w_v0 = 1'b0;
            w_v1 = 1'b0;
        end
        if (!w_v0) begin
            w_d0 = NOP;
            w_p0 = 32'h0;
        end
        w_occ = {1'b0, w_v0} + {1'b0, w_v1};
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_pc       = r_pc;
        w_discard  = r_discard;
        w_err      = r_err;
        w_mem_re   = 1'b0;
        w_mem_addr = r_mem_addr;
        w_try      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_cnt = '0;
                    w_try = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_REQ: begin
                if (r_mem_re) begin
                    // The ROM has already latched this request; a redirect must drop its answer.
                    w_state = S_WAIT;
                    w_cnt   = '0;
                    if (redirect_valid) w_discard = 1'b1;
                end else begin
                    w_try = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_oe) begin
                    w_discard = 1'b0;
                    w_try     = 1'b1;
                    if (w_push) w_pc = r_pc + 32'd4;
                end else begin
                    if (redirect_valid) w_discard = 1'b1;
                    if (r_cnt >= CNT_W'(TIMEOUT - 1) && !redirect_valid) begin
                        w_err   = 1'b1;
                        w_state = S_HALT;
                    end else if (r_cnt < CNT_W'(TIMEOUT - 1)) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (redirect_valid) begin
            w_pc  = redirect_pc & ~32'h3;
            w_err = 1'b0;
        end

        // An in-flight request reserves one FIFO slot, so issue only below two entries.
        if (w_try) begin
            w_state = S_REQ;
            if ({1'b0, w_pc} >= PC_LIMIT) begin
                w_err   = 1'b1;
                w_state = S_HALT;
            end else if (w_occ != 2'd2) begin
                w_mem_re   = 1'b1;
                w_mem_addr = w_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_err      <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_d0       <= NOP;
            r_d1       <= NOP;
            r_p0       <= 32'h0;
            r_p1       <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_pc       <= w_pc;
            r_discard  <= w_discard;
            r_err      <= w_err;
            r_mem_re   <= w_mem_re;
            r_mem_addr <= w_mem_addr;
            r_v0       <= w_v0;
            r_v1       <= w_v1;
            r_d0       <= w_d0;
            r_d1       <= w_d1;
            r_p0       <= w_p0;
            r_p1       <= w_p1;
        end
    end

    assign mem_re     = r_mem_re;
    assign mem_addr   = r_mem_addr;
    assign inst_valid = r_v0;
    assign inst       = r_d0;
    assign inst_pc    = r_p0;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural ROM answering ROM_DELAY+1 cycles after mem_re.
module tb_ifetch;

    localparam int          ROM_DELAY = 5;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_data = 32'h0;
    logic        mem_oe = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rom_cnt = 0;
    logic [31:0] rom_addr = 32'h0;
    logic rom_mute = 1'b0;

    ifetch #(
        .RESET_PC(32'h0000_0000),
        .ADDR_LENGTH(14),
        .ROM_DELAY(ROM_DELAY),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_addr(mem_addr),
        .mem_re(mem_re),
        .mem_data(mem_data),
        .mem_oe(mem_oe),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // ROM without reset: a pending answer survives a DUT reset.
    always @(negedge clk) begin
        mem_oe = 1'b0;
        if (rom_cnt != 0) begin
            rom_cnt = rom_cnt - 1;
            if (rom_cnt == 0) begin
                mem_oe   = 1'b1;
                mem_data = rom_word(rom_addr);
            end
        end
        if (mem_re && !rom_mute) begin
            rom_cnt  = ROM_DELAY + 1;
            rom_addr = mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_re, inst_valid, fetch_err, mem_addr, inst, inst_pc} !== {3'b000, 32'h0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got re=%b v=%b err=%b addr=%h inst=%h pc=%h expected 0 0 0 0 %h 0",
                     mem_re, inst_valid, fetch_err, mem_addr, inst, inst_pc, NOP);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_startup();
        int early;
        do_reset();
        inst_ready = 1'b1;
        early = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (mem_re) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL startup_settle: got %0d early mem_re expected 0", early);
        end
        tick();
        checks++;
        if ({mem_re, mem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL startup_first_req: got re=%b addr=%h expected 1 00000000", mem_re, mem_addr);
        end
        tick();
        checks++;
        if (mem_re !== 1'b0) begin
            errors++;
            $display("FAIL startup_re_pulse: got %b expected 0", mem_re);
        end
        wait_cyc(13);
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL startup_empty_head: got v=%b inst=%h pc=%h expected 0 %h 0", inst_valid, inst, inst_pc, NOP);
        end
        tick();
        checks++;
        if ({inst_valid, inst, inst_pc, mem_re, mem_addr} !== {1'b1, rom_word(32'h0), 32'h0, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL startup_first_inst: got v=%b inst=%h pc=%h re=%b addr=%h expected 1 %h 0 1 4",
                     inst_valid, inst, inst_pc, mem_re, mem_addr, rom_word(32'h0));
        end
        for (int n = 1; n <= 3; n++) begin
            wait_cyc(14 + 7 * n - 1);
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_gap%0d: got valid %b expected 0", n, inst_valid);
            end
            tick();
            checks++;
            if ({inst_valid, inst, inst_pc} !== {1'b1, rom_word(32'(4 * n)), 32'(4 * n)}) begin
                errors++;
                $display("FAIL back_to_back_inst%0d: got v=%b inst=%h pc=%h expected 1 %h %h",
                         n, inst_valid, inst, inst_pc, rom_word(32'(4 * n)), 32'(4 * n));
            end
        end
    endtask

    task automatic test_reset_midop();
        int seen_v;
        int seen_re;
        do_reset();
        inst_ready = 1'b1;
        wait_cyc(16);
        checks++;
        if (mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL midop_pre_addr: got %h expected 00000004", mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_re, inst_valid, fetch_err, mem_addr, inst, inst_pc} !== {3'b000, 32'h0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL midop_async_reset: got re=%b v=%b err=%b addr=%h inst=%h pc=%h",
                     mem_re, inst_valid, fetch_err, mem_addr, inst, inst_pc);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        seen_v = 0;
        seen_re = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (inst_valid) seen_v++;
            if (mem_re && k != 7) seen_re++;
        end
        checks++;
        if ({seen_v, seen_re} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL midop_stale_ignored: got valid=%0d extra_re=%0d expected 0 0", seen_v, seen_re);
        end
        tick();
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, rom_word(32'h0), 32'h0}) begin
            errors++;
            $display("FAIL midop_refetch: got v=%b inst=%h pc=%h expected 1 %h 0", inst_valid, inst, inst_pc, rom_word(32'h0));
        end
    endtask

    task automatic test_backpressure();
        int re_cnt;
        do_reset();
        inst_ready = 1'b0;
        re_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mem_re) re_cnt++;
        end
        checks++;
        if (re_cnt !== 2) begin
            errors++;
            $display("FAIL backpressure_re_count: got %0d expected 2", re_cnt);
        end
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, rom_word(32'h0)}) begin
            errors++;
            $display("FAIL backpressure_head: got v=%b pc=%h inst=%h expected 1 0 %h", inst_valid, inst_pc, inst, rom_word(32'h0));
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({inst_valid, inst_pc, mem_re, mem_addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL backpressure_second: got v=%b pc=%h re=%b addr=%h expected 1 4 1 8", inst_valid, inst_pc, mem_re, mem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_drained: got valid %b expected 0", inst_valid);
        end
        wait_cyc(48);
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h8, rom_word(32'h8)}) begin
            errors++;
            $display("FAIL backpressure_third: got v=%b pc=%h inst=%h expected 1 8 %h", inst_valid, inst_pc, inst, rom_word(32'h8));
        end
    endtask

    task automatic test_redirect_wait();
        int seen_v;
        do_reset();
        inst_ready = 1'b1;
        wait_cyc(9);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        wait_cyc(13);
        checks++;
        if ({mem_re, mem_addr, fetch_err} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL redirect_wait_hold: got re=%b addr=%h err=%b expected 0 0 0", mem_re, mem_addr, fetch_err);
        end
        tick();
        checks++;
        if ({mem_re, mem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL redirect_wait_req: got re=%b addr=%h v=%b expected 1 100 0", mem_re, mem_addr, inst_valid);
        end
        seen_v = 0;
        for (int k = 15; k <= 20; k++) begin
            tick();
            if (inst_valid) seen_v++;
        end
        tick();
        checks++;
        if ({seen_v, inst_valid, inst_pc, inst} !== {32'd0, 1'b1, 32'h100, rom_word(32'h100)}) begin
            errors++;
            $display("FAIL redirect_wait_inst: got early=%0d v=%b pc=%h inst=%h expected 0 1 100 %h",
                     seen_v, inst_valid, inst_pc, inst, rom_word(32'h100));
        end
    endtask

    task automatic test_redirect_oe();
        int seen_v;
        do_reset();
        inst_ready = 1'b1;
        wait_cyc(13);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({mem_re, mem_addr, inst_valid} !== {1'b1, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL redirect_oe_req: got re=%b addr=%h v=%b expected 1 40 0", mem_re, mem_addr, inst_valid);
        end
        seen_v = 0;
        for (int k = 15; k <= 20; k++) begin
            tick();
            if (inst_valid) seen_v++;
        end
        tick();
        checks++;
        if ({seen_v, inst_valid, inst_pc, inst} !== {32'd0, 1'b1, 32'h40, rom_word(32'h40)}) begin
            errors++;
            $display("FAIL redirect_oe_inst: got early=%0d v=%b pc=%h inst=%h expected 0 1 40 %h",
                     seen_v, inst_valid, inst_pc, inst, rom_word(32'h40));
        end
    endtask

    task automatic test_timeout();
        int re_cnt;
        rom_mute = 1'b1;
        do_reset();
        inst_ready = 1'b1;
        wait_cyc(22);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got err %b expected 0", fetch_err);
        end
        tick();
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got err %b expected 1", fetch_err);
        end
        re_cnt = 0;
        for (int k = 24; k <= 30; k++) begin
            tick();
            if (mem_re) re_cnt++;
        end
        checks++;
        if ({re_cnt, fetch_err} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_halt: got re=%0d err=%b expected 0 1", re_cnt, fetch_err);
        end
        rom_mute = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err %b expected 0", fetch_err);
        end
        re_cnt = 0;
        for (int k = 32; k <= 37; k++) begin
            tick();
            if (mem_re) re_cnt++;
        end
        tick();
        checks++;
        if ({re_cnt, mem_re, mem_addr} !== {32'd0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resume: got early=%0d re=%b addr=%h expected 0 1 0", re_cnt, mem_re, mem_addr);
        end
        wait_cyc(45);
        checks++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL timeout_inst: got v=%b pc=%h expected 1 0", inst_valid, inst_pc);
        end
    endtask

    task automatic test_range();
        int bad;
        do_reset();
        inst_ready = 1'b1;
        wait_cyc(9);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0001_0000;
        tick();
        redirect_valid = 1'b0;
        wait_cyc(14);
        checks++;
        if ({fetch_err, mem_re} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL range_err: got err=%b re=%b expected 1 0", fetch_err, mem_re);
        end
        bad = 0;
        for (int k = 15; k <= 30; k++) begin
            tick();
            if (mem_re || inst_valid) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL range_quiet: got %0d active cycles expected 0", bad);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_cyc(38);
        checks++;
        if ({mem_re, mem_addr, fetch_err} !== {1'b1, 32'h0000_FFFC, 1'b0}) begin
            errors++;
            $display("FAIL range_last_word_req: got re=%b addr=%h err=%b expected 1 fffc 0", mem_re, mem_addr, fetch_err);
        end
        wait_cyc(45);
        checks++;
        if ({inst_valid, inst_pc, fetch_err, mem_re} !== {1'b1, 32'h0000_FFFC, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL range_step_out: got v=%b pc=%h err=%b re=%b expected 1 fffc 1 0", inst_valid, inst_pc, fetch_err, mem_re);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_reset_midop();
        test_backpressure();
        test_redirect_wait();
        test_redirect_oe();
        test_timeout();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
